mem_access: RTL and testbench
=============================

MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: clk_i input 1 rising-edge clock; rst_i input 1 synchronous active-high reset.
REQ-002 SHALL have these upstream inputs: reg_waddr_i in RADDR_WIDTH; reg_we_i in 1; reg_wdata_i in RDATA_WIDTH; mem_addr_i in ADDR_WIDTH; mem_data_i in DATA_WIDTH store data; mem_op_i in 4 (MEM_NOP/LB/LH/LW/LBU/LHU/SB/SH/SW, shared defines).
REQ-003 SHALL have these CSR pass-through ports: csr_we_i/o 1; csr_waddr_i/o CSR_ADDR_WIDTH; csr_wdata_i/o DATA_WIDTH.
REQ-004 SHALL have these writeback outputs: reg_waddr_o RADDR_WIDTH; reg_we_o 1; reg_wdata_o RDATA_WIDTH.
REQ-005 SHALL have these bus ports: bus_req_o out 1; bus_we_o out 1; bus_addr_o out 32 word-aligned; bus_wdata_o out 32 lane-replicated; bus_sel_o out 4 byte enables; bus_ack_i in 1; bus_rdata_i in 32.
REQ-006 SHALL have these status outputs: stallreq_o out 1 pipeline hold; bus_err_o out 1 one-cycle timeout pulse.
REQ-007 SHALL have parameter TIMEOUT, default 16, meaning the number of ACCESS cycles without ack before abort.

Function
REQ-008 SHALL implement a three-state FSM: IDLE, ACCESS, DONE.
REQ-009 SHALL, in IDLE with mem_op_i==MEM_NOP, pass reg_*_i and csr_*_i combinationally to outputs with stallreq_o=0 and no state change.
REQ-010 SHALL, in IDLE with a load/store op, drive stallreq_o=1 and reg_we_o=0, latch addr/data/op/sel, and go to ACCESS next edge.
REQ-011 SHALL, in ACCESS, hold bus_req_o=1 with stable addr/we/sel/wdata and stallreq_o=1; on bus_ack_i=1 capture bus_rdata_i and go to DONE.
REQ-012 SHALL, in DONE, drive stallreq_o=0 and present the writeback for one cycle, then return to IDLE.
REQ-013 SHALL give a minimum of 3 cycles per access (ack in first ACCESS cycle), i.e. 2 stall cycles.
REQ-014 SHALL generate byte enables as follows: SB sel=1<<addr[1:0]; SH sel=0011 if addr[1]=0 else 1100; SW sel=1111; loads use the same masks; bus_we_o=1 only for stores.
REQ-015 SHALL form store data as: SB byte replicated x4; SH halfword replicated x2; SW unchanged.
REQ-016 SHALL extract load data by lane: LB/LH sign-extend, LBU/LHU zero-extend, LW full word; reg_wdata_o SHALL equal this value in DONE.
REQ-017 SHALL, for stores, hold reg_we_o=0 in DONE.
REQ-018 SHALL ignore bus_ack_i outside ACCESS.
REQ-019 SHALL, when TIMEOUT ACCESS cycles elapse without ack, pulse bus_err_o, drop bus_req_o, force reg_we_o=0, and go to DONE; an ack arriving in the final cycle wins over the timeout.
REQ-020 SHALL, when csr_we_i accompanies a memory op, emit csr_we_o only in DONE (a single write).

Reset
REQ-021 SHALL, on rst_i=1 at a clock edge, force IDLE, clear the timeout counter and latches, and abandon any in-flight access.
REQ-022 SHALL, while rst_i=1, drive bus_req_o=0, bus_we_o=0, bus_sel_o=0, stallreq_o=0, bus_err_o=0, reg_we_o=0, csr_we_o=0, and all data/address outputs 0.

Configuration
REQ-023 SHALL, with MEM_MISALIGN_CHECK_EN defined, treat a halfword at addr[0]=1 or a word at addr[1:0]!=0 as misaligned: no bus request, misalign_o (out 1) pulses for one cycle, the FSM goes directly IDLE->DONE with reg_we_o=0.
REQ-024 SHALL, without MEM_MISALIGN_CHECK_EN, omit misalign_o; a misaligned access uses the REQ-014 masks on addr[1:0] and the word address addr[31:2].

Verification
REQ-025 SHALL be verified by: LW addr 0x100, ack on first ACCESS cycle, rdata 0xDEADBEEF -> stall 2 cycles, reg_wdata_o=0xDEADBEEF with reg_we_o=1 in DONE.
REQ-026 SHALL be verified by: LB addr 0x103, rdata 0x80112233 -> sel=1000, reg_wdata_o=0xFFFFFF80; LBU -> 0x00000080.
REQ-027 SHALL be verified by: SH addr 0x202, data 0x0000ABCD, ack after 3 wait cycles -> sel=1100, wdata=0xABCDABCD, bus_we_o=1, req held 4 cycles, reg_we_o=0.
REQ-028 SHALL be verified by: LW with no ack -> bus_err_o pulse after 16 ACCESS cycles, FSM returns to IDLE, reg_we_o=0.
REQ-029 SHALL be verified by: rst_i raised in the 2nd ACCESS cycle -> bus_req_o=0 next cycle, IDLE, and a late ack is ignored.
REQ-030 SHALL be verified by: with MEM_MISALIGN_CHECK_EN, LW addr 0x102 -> no bus_req_o, misalign_o pulse, and 1 stall cycle.

Source files
------------

// File: rtl/mem_access.sv
`default_nettype none
// ============================================================================
// Module   : mem_access
// Purpose  : Load/store unit. Stalls the pipeline while it runs one 32-bit bus
//            access, then presents the writeback. Optional build macro:
//            MEM_MISALIGN_CHECK_EN traps misaligned halfword/word accesses.
// Revision : 1.0 - initial release
// ============================================================================
module mem_access #(
  parameter int RADDR_WIDTH    = 5,
  parameter int RDATA_WIDTH    = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int CSR_ADDR_WIDTH = 12,
  parameter int TIMEOUT        = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [RADDR_WIDTH-1:0]    reg_waddr_i,
  input  logic                      reg_we_i,
  input  logic [RDATA_WIDTH-1:0]    reg_wdata_i,
  input  logic [ADDR_WIDTH-1:0]     mem_addr_i,
  input  logic [DATA_WIDTH-1:0]     mem_data_i,
  input  logic [3:0]                mem_op_i,
  input  logic                      csr_we_i,
  input  logic [CSR_ADDR_WIDTH-1:0] csr_waddr_i,
  input  logic [DATA_WIDTH-1:0]     csr_wdata_i,
  output logic                      csr_we_o,
  output logic [CSR_ADDR_WIDTH-1:0] csr_waddr_o,
  output logic [DATA_WIDTH-1:0]     csr_wdata_o,
  output logic [RADDR_WIDTH-1:0]    reg_waddr_o,
  output logic                      reg_we_o,
  output logic [RDATA_WIDTH-1:0]    reg_wdata_o,
  output logic                      bus_req_o,
  output logic                      bus_we_o,
  output logic [31:0]               bus_addr_o,
  output logic [31:0]               bus_wdata_o,
  output logic [3:0]                bus_sel_o,
  input  logic                      bus_ack_i,
  input  logic [31:0]               bus_rdata_i,
  output logic                      stallreq_o,
`ifdef MEM_MISALIGN_CHECK_EN
  output logic                      misalign_o,
`endif
  output logic                      bus_err_o
);

  localparam logic [3:0] MEM_NOP = 4'd0;
  localparam logic [3:0] MEM_LB  = 4'd1;
  localparam logic [3:0] MEM_LH  = 4'd2;
  localparam logic [3:0] MEM_LW  = 4'd3;
  localparam logic [3:0] MEM_LBU = 4'd4;
  localparam logic [3:0] MEM_LHU = 4'd5;
  localparam logic [3:0] MEM_SB  = 4'd6;
  localparam logic [3:0] MEM_SH  = 4'd7;
  localparam logic [3:0] MEM_SW  = 4'd8;

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_e;

  state_e                    state_q;
  logic [CNT_W-1:0]          cnt_q;
  logic [3:0]                op_q;
  logic [31:0]               addr_q;
  logic [1:0]                lane_q;
  logic [3:0]                sel_q;
  logic [31:0]               wdata_q;
  logic                      bus_we_q;
  logic                      req_q;
  logic [31:0]               rdata_q;
  logic                      err_q;
  logic                      bus_err_q;
  logic [RADDR_WIDTH-1:0]    reg_waddr_q;
  logic                      reg_we_q;
  logic                      csr_we_q;
  logic [CSR_ADDR_WIDTH-1:0] csr_waddr_q;
  logic [DATA_WIDTH-1:0]     csr_wdata_q;
`ifdef MEM_MISALIGN_CHECK_EN
  logic                      misalign_q;
`endif

  logic [31:0] addr_w;
  logic [31:0] data_w;
  logic        is_load_d;
  logic        is_store_d;
  logic        mem_valid;
  logic [3:0]  sel_d;
  logic [31:0] wdata_d;
  logic        misalign_d;
  logic        is_load_q;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  assign addr_w = 32'(mem_addr_i);
  assign data_w = 32'(mem_data_i);

  assign is_load_d  = (mem_op_i == MEM_LB) || (mem_op_i == MEM_LH) || (mem_op_i == MEM_LW) ||
                      (mem_op_i == MEM_LBU) || (mem_op_i == MEM_LHU);
  assign is_store_d = (mem_op_i == MEM_SB) || (mem_op_i == MEM_SH) || (mem_op_i == MEM_SW);
  assign mem_valid  = is_load_d || is_store_d;

  // Loads share the store lane masks so the bus sees the bytes actually used.
  always_comb begin
    sel_d   = 4'b0000;
    wdata_d = data_w;
    case (mem_op_i)
      MEM_LB, MEM_LBU: sel_d = 4'b0001 << addr_w[1:0];
      MEM_LH, MEM_LHU: sel_d = addr_w[1] ? 4'b1100 : 4'b0011;
      MEM_LW, MEM_SW:  sel_d = 4'b1111;
      MEM_SB: begin
        sel_d   = 4'b0001 << addr_w[1:0];
        wdata_d = {4{data_w[7:0]}};
      end
      MEM_SH: begin
        sel_d   = addr_w[1] ? 4'b1100 : 4'b0011;
        wdata_d = {2{data_w[15:0]}};
      end
      default: sel_d = 4'b0000;
    endcase
  end

`ifdef MEM_MISALIGN_CHECK_EN
  assign misalign_d = (((mem_op_i == MEM_LH) || (mem_op_i == MEM_LHU) || (mem_op_i == MEM_SH))
                       && addr_w[0]) ||
                      (((mem_op_i == MEM_LW) || (mem_op_i == MEM_SW)) && (addr_w[1:0] != 2'b00));
`else
  assign misalign_d = 1'b0;
`endif

  assign is_load_q = (op_q == MEM_LB) || (op_q == MEM_LH) || (op_q == MEM_LW) ||
                     (op_q == MEM_LBU) || (op_q == MEM_LHU);

  always_comb begin
    case (lane_q)
      2'd0:    ld_byte = rdata_q[7:0];
      2'd1:    ld_byte = rdata_q[15:8];
      2'd2:    ld_byte = rdata_q[23:16];
      default: ld_byte = rdata_q[31:24];
    endcase
    ld_half = lane_q[1] ? rdata_q[31:16] : rdata_q[15:0];
    case (op_q)
      MEM_LB:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      MEM_LBU: ld_data = {24'd0, ld_byte};
      MEM_LH:  ld_data = {{16{ld_half[15]}}, ld_half};
      MEM_LHU: ld_data = {16'd0, ld_half};
      MEM_LW:  ld_data = rdata_q;
      default: ld_data = 32'd0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      op_q        <= MEM_NOP;
      addr_q      <= '0;
      lane_q      <= '0;
      sel_q       <= '0;
      wdata_q     <= '0;
      bus_we_q    <= 1'b0;
      req_q       <= 1'b0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      bus_err_q   <= 1'b0;
      reg_waddr_q <= '0;
      reg_we_q    <= 1'b0;
      csr_we_q    <= 1'b0;
      csr_waddr_q <= '0;
      csr_wdata_q <= '0;
`ifdef MEM_MISALIGN_CHECK_EN
      misalign_q  <= 1'b0;
`endif
    end else begin
      bus_err_q <= 1'b0;
`ifdef MEM_MISALIGN_CHECK_EN
      misalign_q <= 1'b0;
`endif
      case (state_q)
        S_IDLE: begin
          if (mem_valid) begin
            op_q        <= mem_op_i;
            addr_q      <= {addr_w[31:2], 2'b00};
            lane_q      <= addr_w[1:0];
            sel_q       <= sel_d;
            wdata_q     <= wdata_d;
            bus_we_q    <= is_store_d;
            reg_waddr_q <= reg_waddr_i;
            reg_we_q    <= reg_we_i;
            csr_we_q    <= csr_we_i;
            csr_waddr_q <= csr_waddr_i;
            csr_wdata_q <= csr_wdata_i;
            cnt_q       <= '0;
            if (misalign_d) begin
              err_q   <= 1'b1;
              state_q <= S_DONE;
`ifdef MEM_MISALIGN_CHECK_EN
              misalign_q <= 1'b1;
`endif
            end else begin
              err_q   <= 1'b0;
              req_q   <= 1'b1;
              state_q <= S_ACCESS;
            end
          end
        end
        S_ACCESS: begin
          // Ack is tested first so that an ack in the last allowed cycle wins.
          if (bus_ack_i) begin
            rdata_q <= bus_rdata_i;
            req_q   <= 1'b0;
            state_q <= S_DONE;
          end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            req_q     <= 1'b0;
            err_q     <= 1'b1;
            bus_err_q <= 1'b1;
            state_q   <= S_DONE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Every output is forced low while reset is held, even before the first edge.
  always_comb begin
    bus_req_o   = 1'b0;
    bus_we_o    = 1'b0;
    bus_addr_o  = '0;
    bus_wdata_o = '0;
    bus_sel_o   = '0;
    bus_err_o   = 1'b0;
    stallreq_o  = 1'b0;
    reg_waddr_o = '0;
    reg_we_o    = 1'b0;
    reg_wdata_o = '0;
    csr_we_o    = 1'b0;
    csr_waddr_o = '0;
    csr_wdata_o = '0;
    if (!rst_i) begin
      bus_req_o   = req_q;
      bus_we_o    = req_q & bus_we_q;
      bus_addr_o  = addr_q;
      bus_wdata_o = wdata_q;
      bus_sel_o   = sel_q;
      bus_err_o   = bus_err_q;
      case (state_q)
        S_IDLE: begin
          reg_waddr_o = reg_waddr_i;
          csr_waddr_o = csr_waddr_i;
          csr_wdata_o = csr_wdata_i;
          if (mem_valid) begin
            stallreq_o = 1'b1;
          end else begin
            reg_we_o    = reg_we_i;
            reg_wdata_o = reg_wdata_i;
            csr_we_o    = csr_we_i;
          end
        end
        S_ACCESS: begin
          stallreq_o  = 1'b1;
          reg_waddr_o = reg_waddr_q;
          csr_waddr_o = csr_waddr_q;
          csr_wdata_o = csr_wdata_q;
        end
        S_DONE: begin
          reg_waddr_o = reg_waddr_q;
          reg_we_o    = reg_we_q & is_load_q & ~err_q;
          reg_wdata_o = RDATA_WIDTH'(ld_data);
          csr_we_o    = csr_we_q;
          csr_waddr_o = csr_waddr_q;
          csr_wdata_o = csr_wdata_q;
        end
        default: stallreq_o = 1'b0;
      endcase
    end
  end

`ifdef MEM_MISALIGN_CHECK_EN
  assign misalign_o = rst_i ? 1'b0 : misalign_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_access.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access
// Purpose  : Self-checking bench for mem_access; random loads/stores against a
//            transaction-level model. Honours MEM_MISALIGN_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access;

  localparam int TB_TIMEOUT = 16;
  localparam logic [3:0] OP_NOP = 4'd0, OP_LB = 4'd1, OP_LH = 4'd2, OP_LW = 4'd3,
                         OP_LBU = 4'd4, OP_LHU = 4'd5, OP_SB = 4'd6, OP_SH = 4'd7,
                         OP_SW = 4'd8;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [4:0]  reg_waddr_i, reg_waddr_o;
  logic        reg_we_i, reg_we_o;
  logic [31:0] reg_wdata_i, reg_wdata_o;
  logic [31:0] mem_addr_i, mem_data_i;
  logic [3:0]  mem_op_i;
  logic        csr_we_i, csr_we_o;
  logic [11:0] csr_waddr_i, csr_waddr_o;
  logic [31:0] csr_wdata_i, csr_wdata_o;
  logic        bus_req_o, bus_we_o, bus_ack_i, stallreq_o, bus_err_o;
  logic [31:0] bus_addr_o, bus_wdata_o, bus_rdata_i;
  logic [3:0]  bus_sel_o;
`ifdef MEM_MISALIGN_CHECK_EN
  logic        misalign_o;
`endif

  int n_checks = 0;
  int n_bad    = 0;

  always #5 clk_i = ~clk_i;

  mem_access #(.TIMEOUT(TB_TIMEOUT)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .reg_waddr_i(reg_waddr_i), .reg_we_i(reg_we_i), .reg_wdata_i(reg_wdata_i),
    .mem_addr_i(mem_addr_i), .mem_data_i(mem_data_i), .mem_op_i(mem_op_i),
    .csr_we_i(csr_we_i), .csr_waddr_i(csr_waddr_i), .csr_wdata_i(csr_wdata_i),
    .csr_we_o(csr_we_o), .csr_waddr_o(csr_waddr_o), .csr_wdata_o(csr_wdata_o),
    .reg_waddr_o(reg_waddr_o), .reg_we_o(reg_we_o), .reg_wdata_o(reg_wdata_o),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
    .bus_wdata_o(bus_wdata_o), .bus_sel_o(bus_sel_o), .bus_ack_i(bus_ack_i),
    .bus_rdata_i(bus_rdata_i), .stallreq_o(stallreq_o),
`ifdef MEM_MISALIGN_CHECK_EN
    .misalign_o(misalign_o),
`endif
    .bus_err_o(bus_err_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%08h want=0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  function automatic bit m_is_load(input logic [3:0] op);
    return (op >= OP_LB) && (op <= OP_LHU);
  endfunction

  function automatic logic [3:0] m_sel(input logic [3:0] op, input logic [31:0] a);
    int lane = int'(a % 4);
    if (op == OP_LB || op == OP_LBU || op == OP_SB) return 4'(1 << lane);
    if (op == OP_LH || op == OP_LHU || op == OP_SH) return (lane >= 2) ? 4'hC : 4'h3;
    return 4'hF;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [3:0] op, input logic [31:0] d);
    if (op == OP_SB) return (d % 256) * 32'h0101_0101;
    if (op == OP_SH) return (d % 65536) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] m_load(input logic [3:0] op, input logic [31:0] a,
                                         input logic [31:0] rd);
    logic [31:0] v;
    int lane = int'(a % 4);
    if (op == OP_LB || op == OP_LBU) begin
      v = (rd >> (8 * lane)) % 256;
      if (op == OP_LB && v >= 128) v = v + 32'hFFFF_FF00;
    end else if (op == OP_LH || op == OP_LHU) begin
      v = (rd >> (16 * (lane / 2))) % 65536;
      if (op == OP_LH && v >= 32768) v = v + 32'hFFFF_0000;
    end else begin
      v = rd;
    end
    return v;
  endfunction

  function automatic bit m_misaligned(input logic [3:0] op, input logic [31:0] a);
`ifdef MEM_MISALIGN_CHECK_EN
    if ((op == OP_LH || op == OP_LHU || op == OP_SH) && (a % 2 != 0)) return 1'b1;
    if ((op == OP_LW || op == OP_SW) && (a % 4 != 0)) return 1'b1;
`endif
    return (op == 4'hF) && (a == 32'hFFFF_FFFF) && 1'b0;
  endfunction

  // One complete access: IDLE request, ACCESS cycles, DONE, then an IDLE NOP.
  // ack_lat<0 or >=TB_TIMEOUT means the bus never acknowledges.
  task automatic do_access(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] data,
                           input int ack_lat, input logic [31:0] rdata, input logic rwe);
    logic [4:0]  wa;
    logic        cwe;
    logic [11:0] ca;
    logic [31:0] cd, pw;
    bit          mis, ld, tout;
    int          n_acc;
    wa   = 5'($urandom);
    cwe  = 1'($urandom);
    ca   = 12'($urandom);
    cd   = $urandom;
    mis  = m_misaligned(op, addr);
    ld   = m_is_load(op);
    tout = !mis && (ack_lat < 0 || ack_lat >= TB_TIMEOUT);
    n_acc = mis ? 0 : (tout ? TB_TIMEOUT : ack_lat + 1);

    @(posedge clk_i); #1;
    mem_op_i = op; mem_addr_i = addr; mem_data_i = data;
    reg_waddr_i = wa; reg_we_i = rwe; reg_wdata_i = $urandom;
    csr_we_i = cwe; csr_waddr_i = ca; csr_wdata_i = cd;
    bus_ack_i = 1'b0; bus_rdata_i = $urandom;
    @(negedge clk_i);
    chk("idle_stall", 32'(stallreq_o), 32'd1);
    chk("idle_regwe", 32'(reg_we_o), 32'd0);
    chk("idle_csrwe", 32'(csr_we_o), 32'd0);
    chk("idle_req", 32'(bus_req_o), 32'd0);

    for (int k = 0; k < n_acc; k++) begin
      @(posedge clk_i); #1;
      bus_ack_i   = (k == ack_lat);
      bus_rdata_i = (k == ack_lat) ? rdata : $urandom;
      @(negedge clk_i);
      chk("acc_req", 32'(bus_req_o), 32'd1);
      chk("acc_stall", 32'(stallreq_o), 32'd1);
      chk("acc_addr", bus_addr_o, {addr[31:2], 2'b00});
      chk("acc_sel", 32'(bus_sel_o), 32'(m_sel(op, addr)));
      chk("acc_we", 32'(bus_we_o), 32'(!ld));
      if (!ld) chk("acc_wdata", bus_wdata_o, m_wdata(op, data));
      chk("acc_regwe", 32'(reg_we_o), 32'd0);
    end

    @(posedge clk_i); #1;
    bus_ack_i = 1'($urandom);
    bus_rdata_i = $urandom;
    @(negedge clk_i);
    chk("done_stall", 32'(stallreq_o), 32'd0);
    chk("done_req", 32'(bus_req_o), 32'd0);
    chk("done_err", 32'(bus_err_o), 32'(tout));
    chk("done_regwe", 32'(reg_we_o), 32'(ld && rwe && !tout && !mis));
    chk("done_waddr", 32'(reg_waddr_o), 32'(wa));
    if (ld && !tout && !mis) chk("done_wdata", reg_wdata_o, m_load(op, addr, rdata));
    chk("done_csrwe", 32'(csr_we_o), 32'(cwe));
    if (cwe) begin
      chk("done_csraddr", 32'(csr_waddr_o), 32'(ca));
      chk("done_csrdata", csr_wdata_o, cd);
    end
`ifdef MEM_MISALIGN_CHECK_EN
    chk("done_misalign", 32'(misalign_o), 32'(mis));
`endif

    @(posedge clk_i); #1;
    pw = $urandom;
    mem_op_i = OP_NOP; reg_wdata_i = pw; reg_we_i = 1'($urandom); csr_we_i = 1'($urandom);
    bus_ack_i = 1'($urandom);
    @(negedge clk_i);
    chk("nop_stall", 32'(stallreq_o), 32'd0);
    chk("nop_req", 32'(bus_req_o), 32'd0);
    chk("nop_err", 32'(bus_err_o), 32'd0);
    chk("nop_regwe", 32'(reg_we_o), 32'(reg_we_i));
    chk("nop_wdata", reg_wdata_o, pw);
    chk("nop_csrwe", 32'(csr_we_o), 32'(csr_we_i));
`ifdef MEM_MISALIGN_CHECK_EN
    chk("nop_misalign", 32'(misalign_o), 32'd0);
`endif
  endtask

  // Reset raised during the second ACCESS cycle; a late ack must not revive it.
  task automatic reset_mid_access();
    logic [31:0] pw;
    @(posedge clk_i); #1;
    mem_op_i = OP_LW; mem_addr_i = 32'h0000_0400; reg_we_i = 1'b1; bus_ack_i = 1'b0;
    @(posedge clk_i); #1;
    @(negedge clk_i);
    chk("rst_acc1_req", 32'(bus_req_o), 32'd1);
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    @(negedge clk_i);
    chk("rst_hold_req", 32'(bus_req_o), 32'd0);
    chk("rst_hold_stall", 32'(stallreq_o), 32'd0);
    @(posedge clk_i); #1;
    rst_i = 1'b0; mem_op_i = OP_NOP; bus_ack_i = 1'b1; bus_rdata_i = 32'hCAFE_F00D;
    pw = $urandom; reg_wdata_i = pw; reg_we_i = 1'b1;
    @(negedge clk_i);
    chk("rst_after_req", 32'(bus_req_o), 32'd0);
    chk("rst_after_stall", 32'(stallreq_o), 32'd0);
    chk("rst_after_wdata", reg_wdata_o, pw);
    @(posedge clk_i); #1;
    bus_ack_i = 1'b0;
    @(negedge clk_i);
    chk("rst_late_ack_wdata", reg_wdata_o, pw);
    chk("rst_late_ack_err", 32'(bus_err_o), 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] ops [8];
    int         lat, r;
    ops = '{OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW};
    rst_i = 1'b1;
    reg_waddr_i = 5'd3; reg_we_i = 1'b1; reg_wdata_i = 32'h1234_5678;
    mem_addr_i = 32'h100; mem_data_i = 32'hFFFF_FFFF; mem_op_i = OP_LW;
    csr_we_i = 1'b1; csr_waddr_i = 12'h300; csr_wdata_i = 32'h5555_AAAA;
    bus_ack_i = 1'b1; bus_rdata_i = 32'hFFFF_FFFF;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_req", 32'(bus_req_o), 32'd0);
    chk("rst_we", 32'(bus_we_o), 32'd0);
    chk("rst_sel", 32'(bus_sel_o), 32'd0);
    chk("rst_addr", bus_addr_o, 32'd0);
    chk("rst_stall", 32'(stallreq_o), 32'd0);
    chk("rst_regwe", 32'(reg_we_o), 32'd0);
    chk("rst_csrwe", 32'(csr_we_o), 32'd0);
    chk("rst_wdata", reg_wdata_o, 32'd0);
    chk("rst_err", 32'(bus_err_o), 32'd0);
    @(posedge clk_i); #1;
    rst_i = 1'b0; mem_op_i = OP_NOP; bus_ack_i = 1'b0;

    do_access(OP_LW,  32'h0000_0100, $urandom, 0, 32'hDEAD_BEEF, 1'b1);
    do_access(OP_LB,  32'h0000_0103, $urandom, 0, 32'h8011_2233, 1'b1);
    do_access(OP_LBU, 32'h0000_0103, $urandom, 0, 32'h8011_2233, 1'b1);
    do_access(OP_SH,  32'h0000_0202, 32'h0000_ABCD, 3, $urandom, 1'b0);
    do_access(OP_LW,  32'h0000_0300, $urandom, -1, $urandom, 1'b1);
    do_access(OP_LW,  32'h0000_0304, $urandom, TB_TIMEOUT - 1, 32'h1357_9BDF, 1'b1);
    do_access(OP_LW,  32'h0000_0102, $urandom, 0, 32'h0BAD_F00D, 1'b1);
    reset_mid_access();

    for (int i = 0; i < 60; i++) begin
      r = int'($urandom_range(0, 9));
      if (r == 0)      lat = -1;
      else if (r <= 7) lat = int'($urandom_range(0, 3));
      else             lat = int'($urandom_range(4, TB_TIMEOUT - 1));
      do_access(ops[$urandom_range(0, 7)], $urandom, $urandom, lat, $urandom, 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
